// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: job request and array/buffer control bundle.
// slave = controller side, master = job issuer / array side.
interface systolic_ctrl_if #(
  parameter int ARR  = 4,
  parameter int NV_W = 8
);
  localparam int AW = $clog2(ARR);

  logic            start;
  logic            load_wt;
  logic [NV_W-1:0] num_vec;
  logic            mac_control;
  logic            wt_rd_en;
  logic [AW-1:0]   wt_rd_addr;
  logic            act_rd_en;
  logic [NV_W-1:0] act_rd_addr;
  logic [ARR-1:0]  out_valid;
  logic            busy;
  logic            done;

  modport master (
    output start, load_wt, num_vec,
    input  mac_control, wt_rd_en, wt_rd_addr,
    input  act_rd_en, act_rd_addr,
    input  out_valid, busy, done
  );

  modport slave (
    input  start, load_wt, num_vec,
    output mac_control, wt_rd_en, wt_rd_addr,
    output act_rd_en, act_rd_addr,
    output out_valid, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an ARR x ARR weight-stationary MAC array.
// Ports: clk, rst_n (async low); bus.slave carries start/load_wt/num_vec
// in, and mac_control, weight/activation read strobes+addresses,
// out_valid, busy, done out.
module systolic_ctrl #(
  parameter int ARR  = 4,
  parameter int NV_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  systolic_ctrl_if.slave bus
);
  localparam int AW = $clog2(ARR);
  localparam int CW = $clog2(3 * ARR + (1 << NV_W) + 2);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [CW-1:0] C_ARR  = CW'(ARR);
  localparam logic [CW-1:0] C_3ARR = CW'(3 * ARR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NV_W-1:0] nv_q, nv_d;

  logic [CW-1:0] nv_w;
  logic [CW-1:0] act_last;
  logic [CW-1:0] drain_last;

  // Cycle numbers always follow the weight-loading timeline; a job
  // without a weight load simply starts its count at ARR+1.
  assign nv_w       = CW'(nv_q);
  assign act_last   = C_ARR + nv_w;
  assign drain_last = C_3ARR + nv_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && bus.num_vec != '0) begin
          nv_d = bus.num_vec;
          if (bus.load_wt) begin
            state_d = S_WLOAD;
            cnt_d   = C_ONE;
          end else begin
            state_d = S_STREAM;
            cnt_d   = C_ARR + C_ONE;
          end
        end
      end
      // WLOAD spans 1..ARR+1 so every mac_control cycle stays inside it;
      // its last cycle also issues the first activation read.
      S_WLOAD: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == C_ARR + C_ONE) begin
          state_d = (nv_q == NV_W'(1)) ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == act_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + C_ONE;
        if (cnt_q == drain_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic           in_wl;
  logic           in_st;
  logic           busy;
  logic           wen;
  logic           aen;
  logic [ARR-1:0] ov;

  assign in_wl = (state_q == S_WLOAD);
  assign in_st = (state_q == S_STREAM);
  assign busy  = (state_q != S_IDLE);
  assign wen   = in_wl && (cnt_q <= C_ARR);
  assign aen   = (in_wl || in_st) && (cnt_q > C_ARR)
              && (cnt_q <= act_last);

  // Column j sees its results ARR rows deep plus j cycles of skew.
  always_comb begin
    ov = '0;
    for (int j = 0; j < ARR; j++) begin
      if (busy
          && cnt_q >= CW'(2 * ARR + 2 + j)
          && cnt_q <= CW'(2 * ARR + 1 + j) + nv_w) begin
        ov[j] = 1'b1;
      end
    end
  end

  assign bus.mac_control = in_wl && (cnt_q >= C_TWO);
  assign bus.wt_rd_en    = wen;
  assign bus.wt_rd_addr  = wen ? AW'(C_ARR - cnt_q) : '0;
  assign bus.act_rd_en   = aen;
  assign bus.act_rd_addr = aen ? NV_W'(cnt_q - C_ARR - C_ONE) : '0;
  assign bus.out_valid   = ov;
  assign bus.busy        = busy;
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: timeline table, reference-model and MAC-array
// checks for systolic_ctrl.
module tb_systolic_ctrl;
  localparam int ARR  = 4;
  localparam int NV_W = 8;
  localparam int AW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.ARR(ARR), .NV_W(NV_W)) bus ();

  systolic_ctrl #(.ARR(ARR), .NV_W(NV_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic            mac;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic            aen;
    logic [NV_W-1:0] aaddr;
    logic [ARR-1:0]  ov;
    logic            busy;
    logic            done;
  } obs_t;

  typedef struct {
    int   load;
    int   cyc;
    obs_t exp;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  obs_t obs [0:400];
  vec_t tbl [$];

  int Wm [ARR][ARR];
  int Xm [256][ARR];
  int vc [ARR];

  // Behavioural array: buffers, skew, weight-stationary PEs.
  int wdat [ARR];
  int wreg [ARR][ARR];
  int adat [ARR];
  int skq  [ARR][ARR];
  int areg [ARR][ARR];
  int preg [ARR][ARR];

  always @(posedge clk) begin
    if (bus.wt_rd_en)
      for (int c = 0; c < ARR; c++) wdat[c] <= Wm[bus.wt_rd_addr][c];
    if (bus.mac_control)
      for (int r = 0; r < ARR; r++)
        for (int c = 0; c < ARR; c++)
          wreg[r][c] <= (r == 0) ? wdat[c] : wreg[r-1][c];
    for (int r = 0; r < ARR; r++)
      adat[r] <= bus.act_rd_en ? Xm[bus.act_rd_addr][r] : 0;
    for (int r = 0; r < ARR; r++) begin
      skq[r][0] <= adat[r];
      for (int k = 1; k < ARR; k++) skq[r][k] <= skq[r][k-1];
    end
    for (int r = 0; r < ARR; r++)
      for (int c = 0; c < ARR; c++) begin
        int a;
        if (c > 0) a = areg[r][c-1];
        else if (r > 0) a = skq[r][r-1];
        else a = adat[0];
        areg[r][c] <= a;
        preg[r][c] <= ((r == 0) ? 0 : preg[r-1][c]) + a * wreg[r][c];
      end
  end

  function automatic obs_t sample();
    obs_t s;
    s.mac   = bus.mac_control;
    s.wen   = bus.wt_rd_en;
    s.waddr = bus.wt_rd_addr;
    s.aen   = bus.act_rd_en;
    s.aaddr = bus.act_rd_addr;
    s.ov    = bus.out_valid;
    s.busy  = bus.busy;
    s.done  = bus.done;
    return s;
  endfunction

  // Expected outputs in job cycle k, straight from the timing rules.
  function automatic obs_t model(int load, int nv, int k);
    obs_t m;
    int t, lt;
    m  = '0;
    t  = k + ((load != 0) ? 0 : ARR);
    lt = 3 * ARR + nv + 1;
    if (k < 1 || t > lt) return m;
    m.busy = 1'b1;
    m.done = (t == lt);
    if (load != 0) begin
      m.wen = (t <= ARR);
      if (t <= ARR) m.waddr = AW'(ARR - t);
      m.mac = (t >= 2 && t <= ARR + 1);
    end
    if (t >= ARR + 1 && t <= ARR + nv) begin
      m.aen   = 1'b1;
      m.aaddr = NV_W'(t - ARR - 1);
    end
    for (int j = 0; j < ARR; j++)
      if (t >= 2 * ARR + 2 + j && t <= 2 * ARR + 1 + j + nv) m.ov[j] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input int k, input obs_t a,
                     input obs_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  function automatic void mk(int load, int cyc, bit mac, bit wen,
                             int wa, bit aen, int aa, logic [ARR-1:0] ov,
                             bit busy, bit done);
    vec_t v;
    v.load      = load;
    v.cyc       = cyc;
    v.exp.mac   = mac;
    v.exp.wen   = wen;
    v.exp.waddr = AW'(wa);
    v.exp.aen   = aen;
    v.exp.aaddr = NV_W'(aa);
    v.exp.ov    = ov;
    v.exp.busy  = busy;
    v.exp.done  = done;
    tbl.push_back(v);
  endfunction

  task automatic table_check(input int load);
    foreach (tbl[i])
      if (tbl[i].load == load)
        chk("table", tbl[i].cyc, obs[tbl[i].cyc], tbl[i].exp);
  endtask

  task automatic check_results(input int k);
    for (int j = 0; j < ARR; j++) begin
      if (bus.out_valid[j]) begin
        int y;
        y = 0;
        for (int r = 0; r < ARR; r++) y += Xm[vc[j]][r] * Wm[r][j];
        checks++;
        if (preg[ARR-1][j] != y) begin
          failures++;
          $display("FAIL acc cyc=%0d col=%0d vec=%0d got=%0d exp=%0d",
                   k, j, vc[j], preg[ARR-1][j], y);
        end
        vc[j]++;
      end
    end
  endtask

  // smode: 0 = no stray starts, 1 = random stray starts, 2 = starts in
  // cycle 5 and in the done cycle.
  task automatic run_job(input int load, input int nv, input int smode);
    int last;
    obs_t ob;
    last = 3 * ARR + nv + 1 - ((load != 0) ? 0 : ARR);
    if (load != 0)
      for (int r = 0; r < ARR; r++)
        for (int c = 0; c < ARR; c++) Wm[r][c] = $urandom_range(0, 15);
    for (int v = 0; v < nv; v++)
      for (int r = 0; r < ARR; r++) Xm[v][r] = $urandom_range(0, 15);
    for (int j = 0; j < ARR; j++) vc[j] = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.load_wt = (load != 0);
    bus.num_vec = NV_W'(nv);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.load_wt = 1'($urandom);
    bus.num_vec = NV_W'($urandom);
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      ob     = sample();
      obs[k] = ob;
      chk("model", k, ob, model(load, nv, k));
      check_results(k);
      bus.start = 1'b0;
      if (k <= last) begin
        if (smode == 1) begin
          bus.start   = ($urandom_range(0, 2) == 0);
          bus.load_wt = 1'($urandom);
          bus.num_vec = NV_W'($urandom_range(1, 255));
        end else if (smode == 2) begin
          bus.start   = (k == 5 || k == last);
          bus.num_vec = NV_W'(3);
          bus.load_wt = 1'b1;
        end
      end
    end
    bus.start = 1'b0;
    for (int j = 0; j < ARR; j++) chk_int("acc_count", vc[j], nv);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.load_wt = 1'b0;
    bus.num_vec = '0;

    mk(1, 1,  0, 1, 3, 0, 0, 4'b0000, 1, 0);
    mk(1, 2,  1, 1, 2, 0, 0, 4'b0000, 1, 0);
    mk(1, 4,  1, 1, 0, 0, 0, 4'b0000, 1, 0);
    mk(1, 5,  1, 0, 0, 1, 0, 4'b0000, 1, 0);
    mk(1, 6,  0, 0, 0, 1, 1, 4'b0000, 1, 0);
    mk(1, 7,  0, 0, 0, 1, 2, 4'b0000, 1, 0);
    mk(1, 8,  0, 0, 0, 0, 0, 4'b0000, 1, 0);
    mk(1, 10, 0, 0, 0, 0, 0, 4'b0001, 1, 0);
    mk(1, 12, 0, 0, 0, 0, 0, 4'b0111, 1, 0);
    mk(1, 13, 0, 0, 0, 0, 0, 4'b1110, 1, 0);
    mk(1, 15, 0, 0, 0, 0, 0, 4'b1000, 1, 0);
    mk(1, 16, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
    mk(1, 17, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
    mk(0, 1,  0, 0, 0, 1, 0, 4'b0000, 1, 0);
    mk(0, 3,  0, 0, 0, 1, 2, 4'b0000, 1, 0);
    mk(0, 4,  0, 0, 0, 0, 0, 4'b0000, 1, 0);
    mk(0, 6,  0, 0, 0, 0, 0, 4'b0001, 1, 0);
    mk(0, 9,  0, 0, 0, 0, 0, 4'b1110, 1, 0);
    mk(0, 11, 0, 0, 0, 0, 0, 4'b1000, 1, 0);
    mk(0, 12, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
    mk(0, 13, 0, 0, 0, 0, 0, 4'b0000, 0, 0);

    repeat (2) @(negedge clk);
    chk("reset", 0, sample(), '0);
    rst_n = 1'b1;

    run_job(1, 3, 0);
    table_check(1);
    run_job(0, 3, 0);
    table_check(0);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.load_wt = 1'b1;
    bus.num_vec = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("nv_zero", k, sample(), '0);
    end

    run_job(1, 3, 2);
    table_check(1);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.load_wt = 1'b1;
    bus.num_vec = NV_W'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("pre_abort", k, sample(), model(1, 3, k));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", 6, sample(), '0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold", 6, sample(), '0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle", 0, sample(), '0);
    end

    run_job(1, 3, 0);
    table_check(1);

    run_job(1, 255, 0);

    for (int n = 0; n < 12; n++)
      run_job((n == 0) ? 1 : int'($urandom_range(0, 1)),
              int'($urandom_range(1, 24)), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
